mem_io_responder: RTL and testbench

- Device-side responder for the CPU byte-wide memory bus: `mem_a`/`mem_dout`/`mem_wr` from the CPU, `mem_din`/`io_buffer_full` back to it.
- Holds a byte-addressed RAM plus a memory-mapped IO window (UART TX FIFO, UART RX byte, simulation-stop register).
- Replaces the hand-written RAM/IO glue in the SoC top, giving the CPU a single, verifiable far end of its bus.

---
 rtl/mem_io_responder_pkg.sv | 23 ++
 rtl/byte_fifo.sv | 45 ++++
 rtl/mem_io_responder.sv | 111 +++++++++++
 tb/tb_mem_io_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared address map and access decode for the CPU bus responder.
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE     = 18'h30000;
    localparam logic [17:0] IO_UART_OFS = 18'd0;
    localparam logic [17:0] IO_STOP_OFS = 18'd4;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_UART,
        SEL_STOP,
        SEL_IDLE
    } acc_sel_e;

    // Anything with a[17:16] == 2'b11 is IO space; unmapped IO offsets land in SEL_IDLE.
    function automatic acc_sel_e decode_sel(input logic [17:0] a);
        if (a[17:16] != IO_BASE[17:16]) return SEL_RAM;
        if (a == IO_BASE + IO_UART_OFS) return SEL_UART;
        if (a == IO_BASE + IO_STOP_OFS) return SEL_STOP;
        return SEL_IDLE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with occupancy count; a push into a full FIFO only lands if a pop frees a slot.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  mem_q [0:DEPTH-1];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Far end of the CPU byte bus: inline RAM, UART TX FIFO / RX byte, and the stop register.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 8,
    parameter int FULL_MARGIN = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  mem_dout,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic        tx_overflow,
    output logic        sim_done
);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_THR = CW'(TX_DEPTH - FULL_MARGIN);

    logic [7:0] ram_q [0:(2**ADDR_WIDTH)-1];

    acc_sel_e      sel;
    logic [CW-1:0] fifo_count, count_next;
    logic          fifo_empty, fifo_full;
    logic          push, pop, push_ok, overflow, stop_wr, repeat_rd, pop_d;
    logic [7:0]    mem_din_d, mem_din_q;
    logic [31:0]   prev_a_q;
    logic          prev_wr_q, rx_pop_q, full_q, ovf_q, done_q;

    assign sel       = decode_sel(mem_a[17:0]);
    assign push      = rdy & mem_wr & (sel == SEL_UART);
    assign pop       = rdy & tx_valid & tx_ready;
    assign push_ok   = push & (~fifo_full | pop);
    assign overflow  = push & fifo_full & ~pop;
    assign stop_wr   = mem_wr & (sel == SEL_STOP);
    assign count_next = fifo_count + CW'(push_ok) - CW'(pop);
    // A CPU stalled on the same UART read must not consume a second RX byte.
    assign repeat_rd = ~mem_wr & ~prev_wr_q & (prev_a_q == mem_a);

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (mem_dout),
        .dout  (tx_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        mem_din_d = mem_din_q;
        pop_d     = 1'b0;
        if (!mem_wr) begin
            case (sel)
                SEL_RAM:  mem_din_d = ram_q[mem_a[ADDR_WIDTH-1:0]];
                SEL_UART: begin
                    if (!repeat_rd) begin
                        mem_din_d = rx_valid ? rx_data : 8'h00;
                        pop_d     = rx_valid;
                    end
                end
                SEL_STOP: mem_din_d = {7'b0, fifo_empty};
                default:  mem_din_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && mem_wr && sel == SEL_RAM) ram_q[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_din_q <= 8'h00;
            rx_pop_q  <= 1'b0;
            prev_a_q  <= 32'h0;
            prev_wr_q <= 1'b0;
            full_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else if (rdy) begin
            mem_din_q <= mem_din_d;
            rx_pop_q  <= pop_d;
            prev_a_q  <= mem_a;
            prev_wr_q <= mem_wr;
            full_q    <= (count_next >= FULL_THR);
            if (overflow) ovf_q  <= 1'b1;
            if (stop_wr)  done_q <= 1'b1;
        end
    end

    assign mem_din        = mem_din_q;
    assign rx_pop         = rx_pop_q & rdy;
    assign tx_valid       = ~fifo_empty;
    assign io_buffer_full = full_q;
    assign tx_overflow    = ovf_q;
    assign sim_done       = done_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, TX FIFO, RX read, rdy stall, stop register, async reset.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full, tx_valid, tx_ready, rx_valid, rx_pop, tx_overflow, sim_done;
    logic [7:0]  tx_data, rx_data;

    int total = 0;
    int bad   = 0;
    int pops;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
        .tx_overflow(tx_overflow), .sim_done(sim_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        bus(32'h10, 1'b0, 8'h00);
        cyc(); cyc();
        chk("rst_mem_din", mem_din, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_full", io_buffer_full, 0);
        chk("rst_rx_pop", rx_pop, 0);
        chk("rst_ovf", tx_overflow, 0);
        chk("rst_done", sim_done, 0);
        rst = 1'b1;

        // RAM write then read-after-write, plus a top-of-RAM location
        bus(32'h10, 1'b1, 8'hA5);    cyc();
        bus(32'h1FFFF, 1'b1, 8'h5A); cyc();
        bus(32'h11, 1'b1, 8'h3C);    cyc();
        bus(32'h10, 1'b0, 8'h00);    cyc();
        chk("ram_rd_10", mem_din, 8'hA5);
        bus(32'h1FFFF, 1'b0, 8'h00); cyc();
        chk("ram_rd_1ffff", mem_din, 8'h5A);
        bus(32'h11, 1'b0, 8'h00);    cyc();
        chk("ram_rd_11", mem_din, 8'h3C);

        // Fill TX FIFO with the drain stalled
        for (int i = 1; i <= 9; i++) begin
            bus(32'h30000, 1'b1, 8'(i));
            cyc();
            if (i == 5) chk("full_after5", io_buffer_full, 0);
            if (i == 6) chk("full_after6", io_buffer_full, 1);
            if (i == 8) chk("ovf_after8", tx_overflow, 0);
            if (i == 9) chk("ovf_after9", tx_overflow, 1);
        end
        bus(32'h10, 1'b0, 8'h00);
        tx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_valid", tx_valid, 1);
            chk("drain_data", tx_data, 32'(k));
            chk("drain_full", io_buffer_full, (9 - k >= 6) ? 1 : 0);
            cyc();
        end
        chk("drained_valid", tx_valid, 0);
        chk("drained_full", io_buffer_full, 0);
        tx_ready = 1'b0;

        // UART RX read held for three cycles
        rx_valid = 1'b1; rx_data = 8'h3C;
        bus(32'h30000, 1'b0, 8'h00);
        pops = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rx_data", mem_din, 8'h3C);
            if (rx_pop) pops++;
        end
        bus(32'h10, 1'b0, 8'h00);
        cyc();
        if (rx_pop) pops++;
        chk("rx_pop_count", pops, 1);
        rx_valid = 1'b0;
        bus(32'h30000, 1'b0, 8'h00); cyc();
        chk("rx_empty_rd", mem_din, 8'h00);
        chk("rx_empty_nopop", rx_pop, 0);
        bus(32'h30004, 1'b0, 8'h00); cyc();
        chk("stop_rd_empty", mem_din, 8'h01);
        bus(32'h30008, 1'b0, 8'h00); cyc();
        chk("unmapped_rd", mem_din, 8'h00);

        // rdy stall: nothing moves
        bus(32'h30000, 1'b1, 8'h42); cyc();
        bus(32'h10, 1'b0, 8'h00);    cyc();
        chk("pre_stall_din", mem_din, 8'hA5);
        rdy = 1'b0; tx_ready = 1'b1;
        bus(32'h30000, 1'b1, 8'hEE);
        for (int k = 0; k < 2; k++) begin
            cyc();
            tx_ready = ~tx_ready;
            chk("stall_valid", tx_valid, 1);
            chk("stall_head", tx_data, 8'h42);
        end
        rx_valid = 1'b1; rx_data = 8'h99;
        bus(32'h30000, 1'b0, 8'h00);
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("stall_nopop", rx_pop, 0);
            chk("stall_din", mem_din, 8'hA5);
        end
        bus(32'h10, 1'b0, 8'h00);
        rx_valid = 1'b0; tx_ready = 1'b1; rdy = 1'b1;
        cyc();
        tx_ready = 1'b0;
        chk("unstall_drained", tx_valid, 0);

        // Stop register, then async reset between edges
        bus(32'h30000, 1'b1, 8'h55); cyc();
        bus(32'h30004, 1'b1, 8'h00); cyc();
        chk("done_set", sim_done, 1);
        bus(32'h10, 1'b0, 8'h00); cyc(); cyc();
        chk("done_sticky", sim_done, 1);
        chk("pre_rst_din", mem_din, 8'hA5);
        chk("pre_rst_valid", tx_valid, 1);
        chk("pre_rst_ovf", tx_overflow, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_din", mem_din, 0);
        chk("arst_valid", tx_valid, 0);
        chk("arst_full", io_buffer_full, 0);
        chk("arst_rx_pop", rx_pop, 0);
        chk("arst_ovf", tx_overflow, 0);
        chk("arst_done", sim_done, 0);
        cyc();
        rst = 1'b1;
        tx_ready = 1'b1;
        cyc(); cyc();
        chk("post_rst_no_tx", tx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
